alu_result_stage: RTL and testbench



---
 rtl/alu_result_stage.sv | 150 +++++++++++++++
 tb/tb_alu_result_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-stage back end behind the 64-bit ALU.
// - Derives N/Z/C/V from the ALU result and carry-out and commits them to an
//   architectural flags register on accepted ops that request it.
// - Forwards {result, tag} to the memory stage through a 2-entry skid buffer.
//   inReady depends only on registered occupancy (and reset), never on
//   outReady, so downstream stalls never form a combinational ready path.
// Optional build macro: ALU_FLAGS_BYPASS_EN adds the flagsNext output, which
// forwards the flags being committed this cycle to branch resolution.
module alu_result_stage #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] aluOut,
  input  logic             cOut,
  input  logic             aMsb,
  input  logic             bMsb,
  input  logic [2:0]       ctrl,
  input  logic             setFlags,
  input  logic [TAG_W-1:0] rdTag,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outResult,
  output logic [TAG_W-1:0] outTag,
  output logic [3:0]       flags
`ifdef ALU_FLAGS_BYPASS_EN
  ,
  output logic [3:0]       flagsNext
`endif
);

  // Only the arithmetic ops produce carry/overflow; everything else clears them.
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Buffer state: slot 0 is always the oldest entry (the visible head).
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] res_q [2];
  logic [WIDTH-1:0] res_d [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];
  logic [3:0]       flags_q, flags_d;

  logic             accept;
  logic             pop;
  logic [3:0]       derived_flags;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             res_msb;

  // Handshake: ready comes from occupancy only; flush and reset veto transfers.
  assign inReady   = ~reset & (count_q != 2'd2);
  assign outValid  = (count_q != 2'd0);
  assign outResult = res_q[0];
  assign outTag    = tag_q[0];
  assign flags     = flags_q;

  assign accept = inValid & inReady & ~flush & ~reset;
  assign pop    = outValid & outReady & ~flush;

  assign res_msb = aluOut[WIDTH-1];

  // Condition-flag derivation from the current ALU result and operand signs.
  always_comb begin
    flag_n = res_msb;
    flag_z = (aluOut == '0);
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (ctrl)
      OP_ADD: begin
        // Same-sign operands producing a result of the other sign overflow.
        flag_c = cOut;
        flag_v = (aMsb == bMsb) & (res_msb != aMsb);
      end
      OP_SUB: begin
        // cOut is the inverted borrow; overflow needs opposite-sign operands.
        flag_c = cOut;
        flag_v = (aMsb != bMsb) & (res_msb != aMsb);
      end
      default: begin
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
    endcase
    derived_flags = {flag_n, flag_z, flag_c, flag_v};
  end

  // Flags register commits in acceptance order, regardless of downstream pops.
  always_comb begin
    flags_d = flags_q;
    if (accept && setFlags) begin
      flags_d = derived_flags;
    end
  end

`ifdef ALU_FLAGS_BYPASS_EN
  // Same-cycle forward of the value the flags register is about to load.
  always_comb begin
    flagsNext = flags_d;
  end
`endif

  // Skid-buffer next state: shift on pop, append at the tail on accept.
  always_comb begin
    count_d = count_q;
    res_d   = res_q;
    tag_d   = tag_q;
    if (accept && pop) begin
      // Only reachable at count 1: the head leaves and the new entry takes
      // its place, so occupancy and ordering are both unchanged.
      res_d[0] = aluOut;
      tag_d[0] = rdTag;
    end else if (accept) begin
      res_d[count_q[0]] = aluOut;
      tag_d[count_q[0]] = rdTag;
      count_d           = count_q + 2'd1;
    end else if (pop) begin
      res_d[0] = res_q[1];
      tag_d[0] = tag_q[1];
      count_d  = count_q - 2'd1;
    end
    // Flush empties the buffer; stale data may remain but is never valid.
    if (flush) begin
      count_d = 2'd0;
    end
  end

  // State registers with synchronous reset clearing data, count and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      flags_q <= 4'b0000;
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= res_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed vectors with literal expectations,
// plus a queue-based reference model compared on every negative clock edge.
// Build with ALU_FLAGS_BYPASS_EN defined to also check flagsNext.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [63:0] aluOut;
  logic        cOut;
  logic        aMsb;
  logic        bMsb;
  logic [2:0]  ctrl;
  logic        setFlags;
  logic [4:0]  rdTag;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [63:0] outResult;
  logic [4:0]  outTag;
  logic [3:0]  flags;
`ifdef ALU_FLAGS_BYPASS_EN
  logic [3:0]  flagsNext;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_result_stage #(.WIDTH(64), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .aluOut(aluOut), .cOut(cOut), .aMsb(aMsb), .bMsb(bMsb), .ctrl(ctrl),
    .setFlags(setFlags), .rdTag(rdTag), .flush(flush), .outValid(outValid),
    .outReady(outReady), .outResult(outResult), .outTag(outTag), .flags(flags)
`ifdef ALU_FLAGS_BYPASS_EN
    , .flagsNext(flagsNext)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags as defined by the op semantics: N sign, Z zero, C/V only for add/sub.
  function automatic logic [3:0] derive(input logic [63:0] v, input logic c,
                                        input logic am, input logic bm, input logic [2:0] op);
    logic n, z, cf, vf;
    n = v[63];
    z = (v == 64'd0);
    cf = 1'b0;
    vf = 1'b0;
    if (op == 3'b010) begin
      cf = c;
      vf = (am == bm) && (n != am);
    end else if (op == 3'b011) begin
      cf = c;
      vf = (am != bm) && (n != am);
    end
    return {n, z, cf, vf};
  endfunction

  // Reference model: a FIFO of at most two entries plus a flags value.
  typedef struct packed { logic [63:0] res; logic [4:0] tag; } entry_t;
  entry_t     mq[$];
  logic [3:0] mflags = 4'b0000;
  bit         started = 0;
  logic [4:0] popped[$];

  always @(posedge clk) begin : model
    bit acc, pp;
    if (reset) begin
      mq.delete();
      mflags = 4'b0000;
      started = 1;
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = inValid && (mq.size() < 2);
      pp  = (mq.size() > 0) && outReady;
      if (acc && setFlags) mflags = derive(aluOut, cOut, aMsb, bMsb, ctrl);
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back('{res: aluOut, tag: rdTag});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    bit acc_now;
    logic [3:0] fn_exp;
    if (started) begin
      check("inReady", {63'd0, inReady}, {63'd0, (!reset && mq.size() < 2)});
      check("outValid", {63'd0, outValid}, {63'd0, (mq.size() > 0)});
      if (mq.size() > 0) begin
        check("outResult", outResult, mq[0].res);
        check("outTag", {59'd0, outTag}, {59'd0, mq[0].tag});
      end
      check("flags", {60'd0, flags}, {60'd0, mflags});
      acc_now = inValid && !flush && !reset && (mq.size() < 2);
      fn_exp = (acc_now && setFlags) ? derive(aluOut, cOut, aMsb, bMsb, ctrl) : mflags;
`ifdef ALU_FLAGS_BYPASS_EN
      check("flagsNext", {60'd0, flagsNext}, {60'd0, fn_exp});
`endif
      if (outValid && outReady && !flush && !reset) popped.push_back(outTag);
    end
  end

  task automatic drive(input logic v, input logic [63:0] a, input logic c, input logic am,
                       input logic bm, input logic [2:0] op, input logic sf, input logic [4:0] tg);
    inValid = v; aluOut = a; cOut = c; aMsb = am; bMsb = bm; ctrl = op;
    setFlags = sf; rdTag = tg;
    @(posedge clk);
    #1;
    $display("cycle t=%0t v=%0b op=%0d tag=%0d rst=%0b fl=%0b ordy=%0b -> ovalid=%0b otag=%0d flags=%b",
             $time, v, op, tg, reset, flush, outReady, outValid, outTag, flags);
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
  endtask

  initial begin
    bit was_ready, done;
    reset = 1'b1; flush = 1'b0; outReady = 1'b0;
    inValid = 1'b0; aluOut = '0; cOut = 0; aMsb = 0; bMsb = 0; ctrl = 0; setFlags = 0; rdTag = 0;

    // Reset held for two cycles, then released.
    idle(); idle();
    check("rst_outValid", {63'd0, outValid}, 64'd0);
    check("rst_flags", {60'd0, flags}, 64'd0);
    check("rst_outResult", outResult, 64'd0);
    check("rst_inReady_low", {63'd0, inReady}, 64'd0);
    reset = 1'b0;
    idle();
    check("release_inReady", {63'd0, inReady}, 64'd1);

    // ADD overflow: 0x7.. + 0x0.. style operands giving a negative result.
    drive(1, 64'h8000_0000_0000_0000, 0, 0, 0, 3'b010, 1, 5'd3);
    check("add_outValid", {63'd0, outValid}, 64'd1);
    check("add_outResult", outResult, 64'h8000_0000_0000_0000);
    check("add_outTag", {59'd0, outTag}, 64'd3);
    check("add_flags", {60'd0, flags}, 64'b1001);
    outReady = 1'b1;
    idle();
    check("add_drained", {63'd0, outValid}, 64'd0);

    // SUB of equal operands, then AND without a flag commit.
    drive(1, 64'd0, 1, 1, 1, 3'b011, 1, 5'd4);
    check("sub_flags", {60'd0, flags}, 64'b0110);
    drive(1, 64'h5, 0, 0, 1, 3'b100, 0, 5'd5);
    check("and_flags_hold", {60'd0, flags}, 64'b0110);
    check("and_head_tag", {59'd0, outTag}, 64'd5);
    idle(); idle();

    // Back-pressure: two fill the buffer, the third waits for space.
    popped.delete();
    outReady = 1'b0;
    drive(1, 64'h11, 0, 0, 0, 3'b101, 0, 5'd1);
    drive(1, 64'h22, 0, 0, 0, 3'b101, 0, 5'd2);
    check("bp_full_inReady", {63'd0, inReady}, 64'd0);
    drive(1, 64'h33, 0, 0, 0, 3'b101, 0, 5'd3);
    check("bp_head_tag", {59'd0, outTag}, 64'd1);
    check("bp_head_stable", outResult, 64'h11);
    outReady = 1'b1;
    done = 0;
    for (int k = 0; k < 6 && !done; k++) begin
      was_ready = inReady;
      drive(1, 64'h33, 0, 0, 0, 3'b101, 0, 5'd3);
      if (was_ready) done = 1;
    end
    check("bp_tag3_accepted", {63'd0, done}, 64'd1);
    idle(); idle(); idle();
    check("bp_pop_count", popped.size(), 64'd3);
    for (int k = 0; k < popped.size() && k < 3; k++)
      check("bp_pop_order", {59'd0, popped[k]}, k + 1);

    // Sustained push/pop at occupancy 1.
    popped.delete();
    for (int k = 0; k < 10; k++) begin
      drive(1, 64'(k * 64'h0123_4567_89ab_cdef), k[0], k[1], k[2], 3'b010 + 3'(k % 2), 1, 5'(10 + k));
      check("tp_inReady", {63'd0, inReady}, 64'd1);
      check("tp_outValid", {63'd0, outValid}, 64'd1);
    end
    idle(); idle();
    check("tp_pop_count", popped.size(), 64'd10);
    for (int k = 0; k < popped.size() && k < 10; k++)
      check("tp_pop_order", {59'd0, popped[k]}, 10 + k);

    // Flush with two buffered entries and an incoming flag-setting op.
    outReady = 1'b0;
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 3'b010, 1, 5'd7);
    check("fl_pre_flags", {60'd0, flags}, 64'b1000);
    drive(1, 64'h42, 0, 0, 0, 3'b000, 0, 5'd8);
    flush = 1'b1;
    inValid = 1; aluOut = 64'd0; ctrl = 3'b101; setFlags = 1; rdTag = 5'd9;
    #2;
`ifdef ALU_FLAGS_BYPASS_EN
    check("fl_flagsNext", {60'd0, flagsNext}, 64'b1000);
`endif
    drive(1, 64'd0, 0, 0, 0, 3'b101, 1, 5'd9);
    flush = 1'b0;
    check("fl_outValid", {63'd0, outValid}, 64'd0);
    check("fl_flags_kept", {60'd0, flags}, 64'b1000);
    check("fl_inReady", {63'd0, inReady}, 64'd1);

    // Reset while stalled with a full buffer.
    drive(1, 64'hAB, 0, 0, 0, 3'b110, 1, 5'd12);
    drive(1, 64'hCD, 0, 0, 0, 3'b110, 1, 5'd13);
    reset = 1'b1;
    idle();
    check("rs_outValid", {63'd0, outValid}, 64'd0);
    check("rs_outResult", outResult, 64'd0);
    check("rs_outTag", {59'd0, outTag}, 64'd0);
    check("rs_flags", {60'd0, flags}, 64'd0);
    reset = 1'b0;
    idle();
    check("rs_release_inReady", {63'd0, inReady}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
